// File: rtl/fmac_pkg.sv
// Shared definitions for the MAC's shared-adder arbiter slice.
package fmac_pkg;

  localparam int unsigned FP_W_DEF    = 32;
  localparam int unsigned ADD_LAT_DEF = 3;
  localparam int unsigned MAX_OUT_DEF = 4;

  // Owner of an adder operation: the MAC lane or the external add port.
  typedef enum logic {
    REQ_MAC = 1'b0,
    REQ_EXT = 1'b1
  } req_id_t;

endpackage

// File: rtl/fmac_add_arbiter_if.sv
// Requester, adder and response signals of the shared-adder arbiter.
interface fmac_add_arbiter_if
  import fmac_pkg::*;
#(
  parameter int unsigned FP_W = FP_W_DEF
);

  logic            req0_valid;
  logic            req0_ready;
  logic [FP_W-1:0] req0_a;
  logic [FP_W-1:0] req0_b;
  logic            req1_valid;
  logic            req1_ready;
  logic [FP_W-1:0] req1_a;
  logic [FP_W-1:0] req1_b;
  logic            add_issue;
  logic [FP_W-1:0] add_a;
  logic [FP_W-1:0] add_b;
  logic [FP_W-1:0] add_result;
  logic            resp0_valid;
  logic            resp1_valid;
  logic [FP_W-1:0] resp_data;
  logic            busy;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  add_result,
    output req0_ready, req1_ready,
    output add_issue, add_a, add_b,
    output resp0_valid, resp1_valid, resp_data, busy
  );

  // Requester / adder side.
  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output add_result,
    input  req0_ready, req1_ready,
    input  add_issue, add_a, add_b,
    input  resp0_valid, resp1_valid, resp_data, busy
  );

endinterface

// File: rtl/fmac_tag_pipe.sv
// {valid, id} delay line matching the shared adder latency.
module fmac_tag_pipe
  import fmac_pkg::*;
#(
  parameter int unsigned DEPTH = ADD_LAT_DEF
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    in_valid,
  input  req_id_t in_id,
  output logic    out_valid,
  output req_id_t out_id,
  output logic    any_valid
);

  logic [DEPTH-1:0] valid_q;
  req_id_t          id_q [DEPTH];

  // Shift tags one stage per cycle; synchronous clear drops everything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int unsigned s = 0; s < DEPTH; s++) begin
        id_q[s] <= REQ_MAC;
      end
    end else begin
      valid_q[0] <= in_valid;
      id_q[0]    <= in_id;
      for (int unsigned s = 1; s < DEPTH; s++) begin
        valid_q[s] <= valid_q[s-1];
        id_q[s]    <= id_q[s-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_id    = id_q[DEPTH-1];
  assign any_valid = |valid_q;

endmodule

// File: rtl/fmac_add_arbiter.sv
// Round-robin arbiter sharing one pipelined FP adder between the MAC lane
// and the external add port, with per-requester credit limits.
module fmac_add_arbiter
  import fmac_pkg::*;
#(
  parameter int unsigned FP_W    = FP_W_DEF,
  parameter int unsigned ADD_LAT = ADD_LAT_DEF,
  parameter int unsigned MAX_OUT = MAX_OUT_DEF
) (
  input logic               clock,
  input logic               reset,
  fmac_add_arbiter_if.slave bus
);

  localparam int unsigned      CNT_W      = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(MAX_OUT);

  req_id_t          rr;
  logic [CNT_W-1:0] credit0, credit1;
  logic             elig0, elig1, grant0, grant1;
  logic             issue_q;
  req_id_t          issue_id;
  logic [FP_W-1:0]  add_a_q, add_b_q, resp_data_q;
  logic             resp0_q, resp1_q;
  logic             ret_valid, tag_busy;
  req_id_t          ret_id;
  logic             ret0, ret1;

  function automatic logic [CNT_W-1:0] credit_next(
    input logic [CNT_W-1:0] cnt,
    input logic             inc,
    input logic             dec
  );
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (inc && !dec) nxt = cnt + CNT_W'(1);
    if (dec && !inc) nxt = cnt - CNT_W'(1);
    return nxt;
  endfunction

  // Grant decision: lone eligible requester wins, ties go to rr.
  always_comb begin
    elig0  = bus.req0_valid && (credit0 < CREDIT_MAX);
    elig1  = bus.req1_valid && (credit1 < CREDIT_MAX);
    grant0 = elig0 && (!elig1 || (rr == REQ_MAC));
    grant1 = elig1 && (!elig0 || (rr == REQ_EXT));
  end

  assign ret0 = ret_valid && (ret_id == REQ_MAC);
  assign ret1 = ret_valid && (ret_id == REQ_EXT);

  // Register the granted operand pair and its owner toward the adder.
  always_ff @(posedge clock) begin
    if (reset) begin
      issue_q  <= 1'b0;
      issue_id <= REQ_MAC;
      add_a_q  <= '0;
      add_b_q  <= '0;
    end else begin
      issue_q <= grant0 || grant1;
      if (grant0) begin
        issue_id <= REQ_MAC;
        add_a_q  <= bus.req0_a;
        add_b_q  <= bus.req0_b;
      end else if (grant1) begin
        issue_id <= REQ_EXT;
        add_a_q  <= bus.req1_a;
        add_b_q  <= bus.req1_b;
      end
    end
  end

  // Round-robin pointer moves to the other requester after each grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr <= REQ_MAC;
    end else if (grant0) begin
      rr <= REQ_EXT;
    end else if (grant1) begin
      rr <= REQ_MAC;
    end
  end

  // Credits count transfers not yet retired from the tag pipe.
  always_ff @(posedge clock) begin
    if (reset) begin
      credit0 <= '0;
      credit1 <= '0;
    end else begin
      credit0 <= credit_next(credit0, grant0, ret0);
      credit1 <= credit_next(credit1, grant1, ret1);
    end
  end

  fmac_tag_pipe #(
    .DEPTH (ADD_LAT)
  ) u_tag_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (issue_q),
    .in_id     (issue_id),
    .out_valid (ret_valid),
    .out_id    (ret_id),
    .any_valid (tag_busy)
  );

  // Capture the retiring result and strobe its owner for one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp0_q     <= 1'b0;
      resp1_q     <= 1'b0;
      resp_data_q <= '0;
    end else begin
      resp0_q <= ret0;
      resp1_q <= ret1;
      if (ret_valid) begin
        resp_data_q <= bus.add_result;
      end
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.add_issue   = issue_q;
  assign bus.add_a       = add_a_q;
  assign bus.add_b       = add_b_q;
  assign bus.resp0_valid = resp0_q;
  assign bus.resp1_valid = resp1_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.busy        = issue_q || tag_busy || resp0_q || resp1_q;

endmodule
